// File: rtl/rr_mux2_stream.sv
// rr_mux2_stream: registered 2:1 stream multiplexer with a valid/ready handshake.
// One of two input channels wins each cycle. The winning word is captured in a
// single-entry output register, and s0 reports which channel it came from.
// Full throughput, 1-cycle latency.
// Optional build macro FIXED_PRIO_EN: channel A always wins when both channels
// are valid, and the round-robin pointer is removed.
// Default (macro undefined): round-robin, where the loser of a contested grant
// is preferred next time.
module rr_mux2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s0
);

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_s0;

  logic             w_pref;
  logic             w_load_en;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept;

`ifdef FIXED_PRIO_EN
  assign w_pref = 1'b0;
`else
  logic r_pref;
  assign w_pref = r_pref;

  // Round-robin pointer: after an accepted word, prefer the channel that lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pref <= 1'b0;
    end else if (w_accept) begin
      r_pref <= ~w_grant_b;
    end
  end
`endif

  // The register can take a word when it is empty, or when it drains this cycle.
  assign w_load_en = !r_out_valid || out_ready;

  // B wins when it is the only valid channel, or when both are valid and B is preferred.
  assign w_grant_b = b_valid && (!a_valid || w_pref);
  assign w_grant_a = a_valid && !w_grant_b;

  // rst masks the readys so that no upstream word is consumed while reset is applied.
  assign a_ready  = !rst && w_load_en && w_grant_a;
  assign b_ready  = !rst && w_load_en && w_grant_b;
  assign w_accept = w_load_en && (w_grant_a || w_grant_b);

  // Output stage: load the granted word, drain when idle, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_s0        <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_grant_b ? b_data : a_data;
      r_s0        <= w_grant_b;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign s0        = r_s0;

endmodule

// File: tb/tb_rr_mux2_stream.sv
// Testbench for rr_mux2_stream.
// Runs a table of per-cycle vectors, then a short hand-written contention run.
// Every word that is accepted goes into a scoreboard queue. When the word shows
// up on the output it is popped and compared against out and s0.
module tb_rr_mux2_stream;

`ifdef FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       exp_ar;
    logic       exp_br;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       src;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       s0;

  int checks = 0;
  int errors = 0;

  sb_t        sb_q[$];
  logic [7:0] exp_out = 8'h00;
  logic       exp_s0  = 1'b0;

  rr_mux2_stream #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s0       (s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one vector, check the readys mid-cycle, push any handshake, then
  // check the registered outputs just after the edge.
  task automatic apply(input vec_t v);
    bit pushed;
    pushed    = 1'b0;
    rst       = v.rst;
    a_valid   = v.av;
    a_data    = v.ad;
    b_valid   = v.bv;
    b_data    = v.bd;
    out_ready = v.ordy;
    @(negedge clk);
    chk({v.name, ".a_ready"}, {7'd0, a_ready}, {7'd0, v.exp_ar});
    chk({v.name, ".b_ready"}, {7'd0, b_ready}, {7'd0, v.exp_br});
    if (a_valid && a_ready === 1'b1) begin
      sb_q.push_back('{data: v.ad, src: 1'b0});
      pushed = 1'b1;
    end else if (b_valid && b_ready === 1'b1) begin
      sb_q.push_back('{data: v.bd, src: 1'b1});
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      sb_q.delete();
      exp_out = 8'h00;
      exp_s0  = 1'b0;
    end else if (pushed && sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      exp_out = e.data;
      exp_s0  = e.src;
    end
    chk({v.name, ".out_valid"}, {7'd0, out_valid}, {7'd0, v.exp_ov});
    chk({v.name, ".out"}, out, exp_out);
    chk({v.name, ".s0"}, {7'd0, s0}, {7'd0, exp_s0});
  endtask

  vec_t vecs[21];

  initial begin
    //            name       rst  av  ad     bv  bd     ordy ar        br         ov
    vecs[0]  = '{"rst0",     1,   1,  8'h11, 1,  8'h44, 1,   0,        0,         0};
    vecs[1]  = '{"rst1",     1,   1,  8'h11, 1,  8'h44, 1,   0,        0,         0};
    vecs[2]  = '{"singleA1", 0,   1,  8'h11, 0,  8'h00, 1,   1,        0,         1};
    vecs[3]  = '{"singleA2", 0,   1,  8'h22, 0,  8'h00, 1,   1,        0,         1};
    vecs[4]  = '{"singleA3", 0,   1,  8'h33, 0,  8'h00, 1,   1,        0,         1};
    vecs[5]  = '{"drain1",   0,   0,  8'h00, 0,  8'h00, 1,   0,        0,         0};
    vecs[6]  = '{"singleB",  0,   0,  8'h00, 1,  8'h44, 1,   0,        1,         1};
    vecs[7]  = '{"cont1",    0,   1,  8'hAA, 1,  8'hBB, 1,   1,        0,         1};
    vecs[8]  = '{"cont2",    0,   1,  8'hAA, 1,  8'hBB, 1,   FP,       !FP,       1};
    vecs[9]  = '{"cont3",    0,   1,  8'hAA, 1,  8'hBB, 1,   1,        0,         1};
    vecs[10] = '{"cont4",    0,   1,  8'hAA, 1,  8'hBB, 1,   FP,       !FP,       1};
    vecs[11] = '{"load5C",   0,   1,  8'h5C, 0,  8'h00, 1,   1,        0,         1};
    vecs[12] = '{"stall1",   0,   1,  8'h66, 1,  8'h77, 0,   0,        0,         1};
    vecs[13] = '{"stall2",   0,   1,  8'h66, 1,  8'h77, 0,   0,        0,         1};
    vecs[14] = '{"stall3",   0,   1,  8'h66, 1,  8'h77, 0,   0,        0,         1};
    vecs[15] = '{"unstall",  0,   1,  8'h66, 1,  8'h77, 1,   FP,       !FP,       1};
    vecs[16] = '{"drain2",   0,   0,  8'h00, 0,  8'h00, 1,   0,        0,         0};
    vecs[17] = '{"load88",   0,   1,  8'h88, 0,  8'h00, 0,   1,        0,         1};
    vecs[18] = '{"midrst",   1,   1,  8'hAA, 1,  8'hBB, 0,   0,        0,         0};
    vecs[19] = '{"postrst1", 0,   1,  8'hAA, 1,  8'hBB, 1,   1,        0,         1};
    vecs[20] = '{"postrst2", 0,   1,  8'hAA, 1,  8'hBB, 1,   FP,       !FP,       1};

    rst       = 1'b1;
    a_valid   = 1'b0;
    a_data    = 8'h00;
    b_valid   = 1'b0;
    b_data    = 8'h00;
    out_ready = 1'b0;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i]);
    end

    // Sustained contention: after postrst2, A is preferred (RR), so the grants
    // alternate A,B,... In fixed-priority mode A wins every time.
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      bit   win_b;
      win_b = !FP && (i % 2 == 1);
      v = '{"fair", 0, 1, 8'hC0 + 8'(i), 1, 8'hD0 + 8'(i), 1, !win_b, win_b, 1};
      apply(v);
    end

    // Valid drops while stalled: the arbiter keeps no lock on a channel.
    apply('{"dropload", 0, 1, 8'h12, 0, 8'h00, 1, 1, 0, 1});
    apply('{"dropstall", 0, 1, 8'h34, 0, 8'h00, 0, 0, 0, 1});
    apply('{"dropB", 0, 0, 8'h00, 1, 8'h56, 1, 0, 1, 1});

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got %0d entries expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux2_stream.md
Name: rr_mux2_stream

Overview:
- Registered 2:1 stream multiplexer with round-robin arbitration.
- Sits directly upstream of the downstream consumer and replaces the free-running select of mux2_1 with a valid/ready handshake-driven grant.
- Picks one of two input channels per cycle, registers the winning word, and reports which source won.
- Output stage is a single-entry pipeline register: full throughput, 1-cycle latency.

Parameters:
- WIDTH, 8, data width of each input and of the output word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- a_data  input  WIDTH  channel A payload
- a_valid  input  1  channel A word present
- a_ready  output  1  channel A word accepted this cycle when a_valid&&a_ready
- b_data  input  WIDTH  channel B payload
- b_valid  input  1  channel B word present
- b_ready  output  1  channel B word accepted this cycle when b_valid&&b_ready
- out  output  WIDTH  registered output payload
- out_valid  output  1  out holds a valid word
- out_ready  input  1  downstream accepts out this cycle
- s0  output  1  source of the word in out: 0 = A, 1 = B

Behaviour:
- Reset: synchronous, active-high.
  - With rst=1 at a rising edge: out=0, out_valid=0, s0=0, round-robin pointer pref=0 (A preferred).
  - rst overrides all other events in that cycle, including a transfer in flight; a held word is discarded.
- Load condition: load_en = !out_valid || out_ready. The register may take a new word when empty or when draining in the same cycle.
- Grant (combinational, from the current valids and pref):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the channel indicated by pref.
  - Neither valid: no grant.
- a_ready = load_en && grant==A. b_ready = load_en && grant==B.
  - At most one ready is high per cycle.
  - Ready never depends on the same-channel valid beyond the grant function.
- On an accepted word (load_en && any grant) at the edge:
  - out <= granted data; s0 <= granted index; out_valid <= 1.
  - pref <= ~granted index, so the loser is preferred next.
- Drain with no new grant (out_valid && out_ready && no valid input): out_valid <= 0. out and s0 hold their last values.
- Stall (out_valid && !out_ready): out, s0 and out_valid hold; both readys are 0; pref holds.
- Latency: a word accepted at edge N is visible on out at edge N (registered). Sustained throughput is one word per cycle.
- Fairness: with both channels continuously valid and out_ready=1, grants alternate A,B,A,B…
- pref changes only on an accepted word, never on stall or idle.
- Input valid dropping without acceptance is legal; the arbiter re-evaluates every cycle and keeps no lock.

Optional Feature:
- Macro FIXED_PRIO_EN.
- Defined: fixed priority. A always wins when both are valid; pref is removed (or tied to 0) and never updates. All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: assert rst for 2 cycles with a_valid=b_valid=1 → out=0, out_valid=0, s0=0, a_ready=b_ready=0 during reset.
- Single channel: A sends 0x11,0x22,0x33 back-to-back with out_ready=1 and b_valid=0 → out shows 0x11,0x22,0x33 on consecutive cycles, s0=0, a_ready=1 throughout.
- Contention: A holds 0xAA, B holds 0xBB, both valid, out_ready=1, for 4 accepts → out sequence 0xAA,0xBB,0xAA,0xBB and s0 sequence 0,1,0,1. With FIXED_PRIO_EN the sequence is 0xAA ×4 with s0=0 and b_ready never high.
- Backpressure: out holds 0x5C, out_ready=0 for 3 cycles while A and B are valid → out=0x5C, out_valid=1, a_ready=b_ready=0, pref unchanged. When out_ready=1, the next word loads the same cycle.
- Drain: out_valid=1, out_ready=1, no input valid → out_valid falls to 0 next edge, out unchanged.
- Mid-operation reset: rst=1 while out_valid=1 and out_ready=0 → next edge out_valid=0, out=0, pref=0. The first post-reset contention grants A.
